// File: rtl/updnmod10_tracker.sv
// Receive-side tracker for a mod-10 up/down count stream: locks onto the digit,
// infers step direction, tracks signed decade wraps and counts illegal samples.
module updnmod10_tracker #(
    parameter int WRAP_W = 8,
    parameter int ERRC_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     smp,
    input  logic [3:0]               cnt_in,
    input  logic                     clr,
    output logic                     lock,
    output logic [3:0]               digit,
    output logic                     moved,
    output logic                     dir,
    output logic signed [WRAP_W-1:0] wraps,
    output logic                     err,
    output logic [ERRC_W-1:0]        err_cnt
);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    localparam logic signed [WRAP_W-1:0] WRAP_ONE = 1;
    localparam logic [ERRC_W-1:0]        ERRC_ONE = 1;
    localparam logic [ERRC_W-1:0]        ERRC_MAX = '1;

    state_t                     r_state;
    logic                       r_lock;
    logic [3:0]                 r_digit;
    logic                       r_moved;
    logic                       r_dir;
    logic signed [WRAP_W-1:0]   r_wraps;
    logic                       r_err;
    logic [ERRC_W-1:0]          r_err_cnt;

    logic       w_in_range;
    logic [3:0] w_up_digit;
    logic [3:0] w_dn_digit;
    logic       w_lock_acq;
    logic       w_hold;
    logic       w_acc_up;
    logic       w_acc_dn;
    logic       w_reject;
    logic       w_wrap_inc;
    logic       w_wrap_dec;

    function automatic logic [ERRC_W-1:0] errc_sat_inc(input logic [ERRC_W-1:0] c);
        return (c == ERRC_MAX) ? c : c + ERRC_ONE;
    endfunction

    // Two's-complement step; overflow past the extremes wraps silently.
    function automatic logic signed [WRAP_W-1:0] wrap_step(
        input logic signed [WRAP_W-1:0] w,
        input logic                     inc,
        input logic                     dec
    );
        if (inc) return w + WRAP_ONE;
        if (dec) return w - WRAP_ONE;
        return w;
    endfunction

    always_comb begin
        w_in_range = (cnt_in <= 4'd9);
        w_up_digit = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
        w_dn_digit = (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
        w_lock_acq = smp && (r_state == ST_UNLOCKED) && w_in_range;
        w_hold     = smp && (r_state == ST_LOCKED) && (cnt_in == r_digit);
        w_acc_up   = smp && (r_state == ST_LOCKED) && (cnt_in == w_up_digit);
        w_acc_dn   = smp && (r_state == ST_LOCKED) && (cnt_in == w_dn_digit);
        w_reject   = smp && !(w_lock_acq || w_hold || w_acc_up || w_acc_dn);
        w_wrap_inc = w_acc_up && (r_digit == 4'd9);
        w_wrap_dec = w_acc_dn && (r_digit == 4'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_UNLOCKED;
            r_lock    <= 1'b0;
            r_digit   <= 4'd0;
            r_moved   <= 1'b0;
            r_dir     <= 1'b1;
            r_wraps   <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_moved <= w_acc_up || w_acc_dn;
            r_err   <= w_reject;
            if (w_lock_acq) begin
                r_state <= ST_LOCKED;
                r_lock  <= 1'b1;
                r_digit <= cnt_in;
            end else if (w_acc_up || w_acc_dn) begin
                r_digit <= cnt_in;
                r_dir   <= w_acc_up;
            end else if (w_reject && (r_state == ST_LOCKED)) begin
                r_state <= ST_UNLOCKED;
                r_lock  <= 1'b0;
            end
            // clr overrides any increment produced by a coincident sample
            if (clr) begin
                r_wraps   <= '0;
                r_err_cnt <= '0;
            end else begin
                r_wraps <= wrap_step(r_wraps, w_wrap_inc, w_wrap_dec);
                if (w_reject) r_err_cnt <= errc_sat_inc(r_err_cnt);
            end
        end
    end

    assign lock    = r_lock;
    assign digit   = r_digit;
    assign moved   = r_moved;
    assign dir     = r_dir;
    assign wraps   = r_wraps;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_updnmod10_tracker.sv
// Scoreboard bench for updnmod10_tracker: directed samples push hand-computed
// expectations; a monitor pops and compares one cycle after each sample.
module tb_updnmod10_tracker;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic       smp = 1'b0, clr = 1'b0;
    logic [3:0] cnt_in = 4'd0;
    logic       lock, moved, dir, err;
    logic [3:0] digit;
    logic signed [7:0] wraps;
    logic [7:0] err_cnt;

    logic       s_smp = 1'b0, s_clr = 1'b0;
    logic [3:0] s_cnt = 4'd0;
    logic       s_lock, s_moved, s_dir, s_err;
    logic [3:0] s_digit;
    logic signed [3:0] s_wraps;
    logic [1:0] s_err_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         sel;
        string      name;
        logic       l;
        logic [3:0] d;
        logic       m;
        logic       dr;
        logic [7:0] w;
        logic       e;
        logic [7:0] ec;
    } exp_t;

    exp_t q[$];
    exp_t e;

    updnmod10_tracker #(.WRAP_W(8), .ERRC_W(8)) dut (
        .clk(clk), .reset(reset), .smp(smp), .cnt_in(cnt_in), .clr(clr),
        .lock(lock), .digit(digit), .moved(moved), .dir(dir),
        .wraps(wraps), .err(err), .err_cnt(err_cnt)
    );

    updnmod10_tracker #(.WRAP_W(4), .ERRC_W(2)) dut_s (
        .clk(clk), .reset(reset), .smp(s_smp), .cnt_in(s_cnt), .clr(s_clr),
        .lock(s_lock), .digit(s_digit), .moved(s_moved), .dir(s_dir),
        .wraps(s_wraps), .err(s_err), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit sel, input string nm, input logic s, input logic [3:0] c,
                        input logic cl, input logic l, input logic [3:0] d, input logic m,
                        input logic dr, input logic [7:0] w, input logic ev, input logic [7:0] ec);
        exp_t x;
        @(negedge clk);
        smp = 1'b0; cnt_in = 4'd0; clr = 1'b0;
        s_smp = 1'b0; s_cnt = 4'd0; s_clr = 1'b0;
        if (sel) begin s_smp = s; s_cnt = c; s_clr = cl; end
        else begin smp = s; cnt_in = c; clr = cl; end
        x.sel = sel; x.name = nm; x.l = l; x.d = d; x.m = m; x.dr = dr;
        x.w = w; x.e = ev; x.ec = ec;
        q.push_back(x);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        smp = 1'b0; clr = 1'b0; s_smp = 1'b0; s_clr = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".lock"}, int'(lock), 0);
        chk({nm, ".digit"}, int'(digit), 0);
        chk({nm, ".moved"}, int'(moved), 0);
        chk({nm, ".dir"}, int'(dir), 1);
        chk({nm, ".wraps"}, int'($unsigned(wraps)), 0);
        chk({nm, ".err"}, int'(err), 0);
        chk({nm, ".err_cnt"}, int'(err_cnt), 0);
    endtask

    // Monitor: every output cycle with a pending expectation is compared
    always @(posedge clk) begin
        #1;
        chk("excl_moved_err", int'(moved && err), 0);
        if (q.size() != 0) begin
            e = q.pop_front();
            if (!e.sel) begin
                chk({e.name, ".lock"}, int'(lock), int'(e.l));
                chk({e.name, ".digit"}, int'(digit), int'(e.d));
                chk({e.name, ".moved"}, int'(moved), int'(e.m));
                chk({e.name, ".dir"}, int'(dir), int'(e.dr));
                chk({e.name, ".wraps"}, int'($unsigned(wraps)), int'(e.w));
                chk({e.name, ".err"}, int'(err), int'(e.e));
                chk({e.name, ".err_cnt"}, int'(err_cnt), int'(e.ec));
            end else begin
                chk({e.name, ".lock"}, int'(s_lock), int'(e.l));
                chk({e.name, ".digit"}, int'(s_digit), int'(e.d));
                chk({e.name, ".moved"}, int'(s_moved), int'(e.m));
                chk({e.name, ".dir"}, int'(s_dir), int'(e.dr));
                chk({e.name, ".wraps"}, int'($unsigned(s_wraps)), int'(e.w & 8'h0F));
                chk({e.name, ".err"}, int'(s_err), int'(e.e));
                chk({e.name, ".err_cnt"}, int'(s_err_cnt), int'(e.ec));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        //    sel name        smp cnt clr  lock dig mov dir wraps err errc
        step(0, "idle",       0, 0, 0,  0, 0, 0, 1, 8'h00, 0, 0);
        step(0, "lock3",      1, 3, 0,  1, 3, 0, 1, 8'h00, 0, 0);
        step(0, "up4",        1, 4, 0,  1, 4, 1, 1, 8'h00, 0, 0);
        step(0, "up5",        1, 5, 0,  1, 5, 1, 1, 8'h00, 0, 0);
        step(0, "nosmp",      0, 0, 0,  1, 5, 0, 1, 8'h00, 0, 0);
        step(0, "up6",        1, 6, 0,  1, 6, 1, 1, 8'h00, 0, 0);
        step(0, "up7",        1, 7, 0,  1, 7, 1, 1, 8'h00, 0, 0);
        step(0, "up8",        1, 8, 0,  1, 8, 1, 1, 8'h00, 0, 0);
        step(0, "up9",        1, 9, 0,  1, 9, 1, 1, 8'h00, 0, 0);
        step(0, "upwrap",     1, 0, 0,  1, 0, 1, 1, 8'h01, 0, 0);
        step(0, "up1",        1, 1, 0,  1, 1, 1, 1, 8'h01, 0, 0);
        step(0, "hold1",      1, 1, 0,  1, 1, 0, 1, 8'h01, 0, 0);
        step(0, "dn0",        1, 0, 0,  1, 0, 1, 0, 8'h01, 0, 0);
        step(0, "dnwrap",     1, 9, 0,  1, 9, 1, 0, 8'h00, 0, 0);
        step(0, "dn8",        1, 8, 0,  1, 8, 1, 0, 8'h00, 0, 0);
        step(0, "hold8",      1, 8, 0,  1, 8, 0, 0, 8'h00, 0, 0);
        step(0, "jump8to2",   1, 2, 0,  0, 8, 0, 0, 8'h00, 1, 1);
        step(0, "clr_lock2",  1, 2, 1,  1, 2, 0, 0, 8'h00, 0, 0);
        step(0, "jump2to5",   1, 5, 0,  0, 2, 0, 0, 8'h00, 1, 1);
        step(0, "relock7",    1, 7, 0,  1, 7, 0, 0, 8'h00, 0, 1);
        step(0, "oor_locked", 1, 12, 0, 0, 7, 0, 0, 8'h00, 1, 2);
        step(0, "oor_unlk",   1, 12, 0, 0, 7, 0, 0, 8'h00, 1, 3);
        step(0, "oor15",      1, 15, 0, 0, 7, 0, 0, 8'h00, 1, 4);
        step(0, "relock7b",   1, 7, 0,  1, 7, 0, 0, 8'h00, 0, 4);
        step(0, "up8b",       1, 8, 0,  1, 8, 1, 1, 8'h00, 0, 4);
        step(0, "up9b",       1, 9, 0,  1, 9, 1, 1, 8'h00, 0, 4);
        step(0, "clr_wrap",   1, 0, 1,  1, 0, 1, 1, 8'h00, 0, 0);
        step(0, "up1b",       1, 1, 0,  1, 1, 1, 1, 8'h00, 0, 0);
        step(0, "dn0b",       1, 0, 0,  1, 0, 1, 0, 8'h00, 0, 0);
        step(0, "dnwrap_neg", 1, 9, 0,  1, 9, 1, 0, 8'hFF, 0, 0);
        step(0, "clr_only",   0, 0, 1,  1, 9, 0, 0, 8'h00, 0, 0);
        for (int w = 1; w <= 3; w++) begin
            step(0, "wrap_up",    1, 0, 0,  1, 0, 1, 1, 8'(w), 0, 0);
            for (int k = 1; k <= 9; k++)
                step(0, "cnt_up", 1, 4'(k), 0, 1, 4'(k), 1, 1, 8'(w), 0, 0);
        end
        step(0, "dn8c",       1, 8, 0,  1, 8, 1, 0, 8'h03, 0, 0);
        step(0, "dn7c",       1, 7, 0,  1, 7, 1, 0, 8'h03, 0, 0);
        step(0, "dn6c",       1, 6, 0,  1, 6, 1, 0, 8'h03, 0, 0);
        drain();

        // Asynchronous reset asserted mid-cycle must act without a clock edge
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step(0, "relock4",    1, 4, 0,  1, 4, 0, 1, 8'h00, 0, 0);

        step(1, "s_oor1",     1, 12, 0, 0, 0, 0, 1, 8'h00, 1, 1);
        step(1, "s_oor2",     1, 12, 0, 0, 0, 0, 1, 8'h00, 1, 2);
        step(1, "s_oor3",     1, 12, 0, 0, 0, 0, 1, 8'h00, 1, 3);
        step(1, "s_oor_sat4", 1, 12, 0, 0, 0, 0, 1, 8'h00, 1, 3);
        step(1, "s_oor_sat5", 1, 12, 0, 0, 0, 0, 1, 8'h00, 1, 3);
        step(1, "s_lock0",    1, 0, 0,  1, 0, 0, 1, 8'h00, 0, 3);
        for (int w = 1; w <= 8; w++) begin
            for (int k = 1; k <= 9; k++)
                step(1, "s_cnt", 1, 4'(k), 0, 1, 4'(k), 1, 1, 8'(w - 1), 0, 3);
            step(1, "s_wrap",     1, 0, 0,  1, 0, 1, 1, 8'(w), 0, 3);
        end
        step(1, "s_clr",      0, 0, 1,  1, 0, 0, 1, 8'h00, 0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/updnmod10_tracker.md
# updnmod10_tracker

Receive-side companion to the mod-10 up/down counter: samples a 4-bit BCD count stream, locks onto it, infers step direction, tracks the signed number of decade wraps, and flags illegal transitions. Sits downstream of any mod-10 counter whose output must be observed across a clock or module boundary, e.g. for position tracking or self-check in the testbench.

## Interface
- WRAP_W, 8, width of the signed (two's-complement) wrap counter
- ERRC_W, 8, width of the saturating error counter

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low
- smp  input  1  sample strobe; cnt_in is evaluated only on cycles with smp=1
- cnt_in  input  4  observed count value; legal range 0..9
- clr  input  1  synchronous clear of wraps and err_cnt
- lock  output  1  1 = tracker has a valid reference digit
- digit  output  4  last legally accepted count value
- moved  output  1  one-cycle pulse: accepted sample differed from digit by one step
- dir  output  1  direction of last move, 1 = up, 0 = down
- wraps  output  WRAP_W  signed net decade wraps (+1 on 9->0 up, -1 on 0->9 down)
- err  output  1  one-cycle pulse: sample rejected
- err_cnt  output  ERRC_W  saturating count of rejected samples

## Operation
- States: UNLOCKED, LOCKED. Reset state UNLOCKED.
- Sample is in-range iff cnt_in <= 9. Let p = digit, n = cnt_in.
- UNLOCKED, smp=1:
  - n in range -> LOCKED, digit<=n, lock<=1; moved=0, wraps unchanged.
  - n out of range -> stay UNLOCKED, err pulse, err_cnt+1.
- LOCKED, smp=1:
  - n == p -> hold; no moved, no err.
  - n == (p+1) mod 10 -> digit<=n, moved pulse, dir<=1; if p=9,n=0 then wraps+1.
  - n == (p+9) mod 10 -> digit<=n, moved pulse, dir<=0; if p=0,n=9 then wraps-1.
  - anything else (jump of >=2, or n>9) -> UNLOCKED, lock<=0, err pulse, err_cnt+1; digit, dir, wraps hold.
- smp=0: no state change; moved and err deassert.
- wraps arithmetic is modulo 2^WRAP_W (wraps from +max to -min silently).
- err_cnt saturates at 2^ERRC_W-1; no further increment.
- clr=1: wraps<=0, err_cnt<=0 on that edge; lock, digit, dir, state unaffected. clr with simultaneous smp: the sample is processed normally for state/digit/dir/moved/err, but its wraps/err_cnt increment is discarded (clr wins).
- Reset values: lock=0, digit=0, moved=0, dir=1, wraps=0, err=0, err_cnt=0, state UNLOCKED.

## Timing
- All outputs registered. Sample presented with smp=1 in cycle k is reflected on outputs after rising edge ending cycle k (latency 1).
- moved and err are high exactly one cycle per qualifying sample; back-to-back qualifying samples give continuously high pulses.
- moved and err never both high in the same cycle.
- Re-lock after error requires one further in-range sample; that sample produces no moved pulse.
- Asynchronous reset mid-stream forces all outputs to reset values immediately; first in-range sample after release re-locks.
- cnt_in must be stable and synchronous to clk when smp=1; no internal synchroniser.

## Test plan
- Lock and count up: reset, smp each cycle with 3,4,5 -> lock=1 after first edge, digit=3; then moved pulses with dir=1, digit=5, wraps=0, err never high.
- Up wrap / down wrap: sequence 8,9,0,1 -> wraps=1, dir=1; then 1,0,9,8 -> wraps=0, dir=0; moved high on every change.
- Illegal jump: locked at 2, sample 5 -> err pulse, err_cnt=1, lock=0, digit stays 2; next sample 7 -> lock=1, digit=7, moved=0.
- Out-of-range: sample 12 while UNLOCKED and LOCKED -> err each time, err_cnt=2, digit unchanged; ERRC_W=2 with 5 bad samples -> err_cnt=3.
- clr collision: locked at 9, assert clr and smp with 0 in same cycle -> digit=0, moved=1, dir=1, wraps=0 (increment discarded); WRAP_W=4 with 8 up-wraps from 0 -> wraps=4'b1000 (-8).
- Reset mid-operation: wraps=3, locked at 6, pulse reset low mid-cycle -> outputs immediately lock=0, digit=0, dir=1, wraps=0, err_cnt=0; after release, sample 4 -> lock=1, digit=4, moved=0.
